averaging_sequencer: RTL

// - Multi-channel control sequencer for the averaging adder; generalises the single-channel

---
 rtl/averaging_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/averaging_sequencer.sv
// Multi-channel clear/settle/add/show sequencer driving the averaging adder and channel mux.
// Optional sticky overrun flag: define AVERAGING_SEQUENCER_OVERRUN_EN.
module averaging_sequencer #(
    parameter int unsigned sample_count  = 9,
    parameter int unsigned channel_count = 1,
    parameter int unsigned settle_cycles = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    output logic clear,
    output logic add,
    output logic show,
    output logic [((channel_count > 1) ? $clog2(channel_count) : 1)-1:0] channel,
    output logic busy
`ifdef AVERAGING_SEQUENCER_OVERRUN_EN
    ,
    output logic overrun
`endif
);

    localparam int unsigned ChW    = (channel_count > 1) ? $clog2(channel_count) : 1;
    localparam int unsigned CntMax = (sample_count > settle_cycles) ? sample_count : settle_cycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] AddLast    = CntW'(sample_count - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(settle_cycles - 1);
    localparam logic [ChW-1:0]  ChLast     = ChW'(channel_count - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StAdd,
        StShow
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ChW-1:0]  channel_q, channel_d;
    logic            trigger_prev_q;
    logic            start;

    assign start = trigger & ~trigger_prev_q;

    // Single counter serves both SETTLE and ADD; it is zeroed on every entry to either.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        channel_d = channel_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                cnt_d   = '0;
                state_d = (settle_cycles > 0) ? StSettle : StAdd;
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StAdd;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAdd: begin
                if (cnt_q == AddLast) begin
                    cnt_d   = '0;
                    state_d = StShow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShow: begin
                if (channel_q == ChLast) begin
                    channel_d = '0;
                    state_d   = StIdle;
                end else begin
                    channel_d = channel_q + 1'b1;
                    state_d   = StClear;
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_d     = '0;
                channel_d = '0;
            end
        endcase
    end

    // trigger_prev resets high so a trigger held through reset does not count as an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            channel_q      <= '0;
            trigger_prev_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            channel_q      <= channel_d;
            trigger_prev_q <= trigger;
        end
    end

    assign clear   = (state_q == StClear);
    assign add     = (state_q == StAdd);
    assign show    = (state_q == StShow);
    assign busy    = (state_q != StIdle);
    assign channel = channel_q;

`ifdef AVERAGING_SEQUENCER_OVERRUN_EN
    logic overrun_q, overrun_d;

    // Sticky until the next accepted start; any start seen while busy sets it.
    always_comb begin
        overrun_d = overrun_q;
        if (start) begin
            overrun_d = (state_q != StIdle);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

endmodule
